// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: command controller between an SPI slave and a single-port
// byte memory. Decodes 10-bit frames ({cmd[1:0], payload[7:0]}), keeps
// separate write/read pointers and runs one memory access at a time over a
// req/ack port with a timeout. Read bytes go back to the slave on tx_*.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   rx_data, rx_valid   - frame from slave; taken on rx_valid rising edge
//   tx_data, tx_valid   - read byte to slave, tx_valid held TX_HOLD cycles
//   mem_req, mem_we,
//   mem_addr, mem_wdata - memory request (held stable until ack/timeout)
//   mem_ack, mem_rdata  - memory completion and read data
//   busy                - controller not idle
//   err                 - one-cycle pulse on timeout or dropped frame
module spi_mem_ctrl #(
    parameter int TX_HOLD  = 8,
    parameter int TIMEOUT  = 16,
    parameter bit AUTO_INC = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, MEM_WR, MEM_RD, TX} state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(TX_HOLD + 1);

    state_t        state, next_state;
    logic          rx_valid_q;
    logic [7:0]    wr_ptr, rd_ptr;
    logic [TW-1:0] tmo_cnt;
    logic [HW-1:0] tx_cnt;

    logic [1:0] cmd;
    logic [7:0] payload;
    logic       acc, ack_hit, tmo_hit, tx_done;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];
    assign acc     = rx_valid & ~rx_valid_q;
    assign ack_hit = mem_req & mem_ack;
    // Ack on the last allowed edge wins, so the timeout needs ~mem_ack.
    assign tmo_hit = mem_req & ~mem_ack & (tmo_cnt == TW'(TIMEOUT - 1));
    assign tx_done = (tx_cnt == HW'(TX_HOLD - 1));
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (acc && cmd == CMD_WR_DATA)      next_state = MEM_WR;
                else if (acc && cmd == CMD_RD_DATA) next_state = MEM_RD;
            end
            MEM_WR: if (ack_hit || tmo_hit) next_state = IDLE;
            MEM_RD: begin
                if (ack_hit)      next_state = TX;
                else if (tmo_hit) next_state = IDLE;
            end
            TX:      if (tx_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tmo_cnt    <= '0;
            tx_cnt     <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            err        <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        case (cmd)
                            CMD_WR_ADDR: wr_ptr <= payload;
                            CMD_RD_ADDR: rd_ptr <= payload;
                            CMD_WR_DATA: begin
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= wr_ptr;
                                mem_wdata <= payload;
                                tmo_cnt   <= '0;
                            end
                            default: begin
                                mem_req  <= 1'b1;
                                mem_we   <= 1'b0;
                                mem_addr <= rd_ptr;
                                tmo_cnt  <= '0;
                            end
                        endcase
                    end
                end
                MEM_WR, MEM_RD: begin
                    if (acc) err <= 1'b1;  // frame dropped while busy
                    if (ack_hit) begin
                        mem_req <= 1'b0;
                        if (AUTO_INC) begin
                            if (state == MEM_WR) wr_ptr <= wr_ptr + 8'd1;
                            else                 rd_ptr <= rd_ptr + 8'd1;
                        end
                        if (state == MEM_RD) begin
                            tx_data  <= mem_rdata;
                            tx_valid <= 1'b1;
                            tx_cnt   <= '0;
                        end
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                TX: begin
                    if (acc) err <= 1'b1;
                    if (tx_done) tx_valid <= 1'b0;
                    else         tx_cnt   <= tx_cnt + HW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: table of single-frame vectors plus
// hand-written sequences for timeout, dropped frames, level-held rx_valid,
// pointer auto-increment and reset during TX. Memory requests and returned
// read bytes are checked against scoreboard queues by a negedge monitor.
module tb_spi_mem_ctrl;
    localparam int TX_HOLD = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    logic [7:0] tx_data, mem_addr, mem_wdata;
    logic       tx_valid, mem_req, mem_we, busy, err;
    logic [7:0] i_tx_data, i_mem_addr, i_mem_wdata;
    logic       i_tx_valid, i_mem_req, i_mem_we, i_busy, i_err;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.TX_HOLD(TX_HOLD), .TIMEOUT(TIMEOUT), .AUTO_INC(1'b0)) u_dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .err(err));

    spi_mem_ctrl #(.TX_HOLD(TX_HOLD), .TIMEOUT(TIMEOUT), .AUTO_INC(1'b1)) u_inc (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(i_tx_data), .tx_valid(i_tx_valid), .mem_req(i_mem_req), .mem_we(i_mem_we),
        .mem_addr(i_mem_addr), .mem_wdata(i_mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(i_busy), .err(i_err));

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct {
        logic [9:0] frame;
        int         k;       // ack on the k-th edge after accept
        logic [7:0] rdata;
        logic       req;     // frame should start a memory access
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } vec_t;

    txn_t       exp_q[$];
    logic [7:0] tx_q[$];

    int n_checks = 0, n_fail = 0;
    int err_cnt = 0, tx_cyc = 0, req_cyc = 0, busy_cyc = 0, req_rises = 0;
    logic        req_q = 1'b0, txv_q = 1'b0;
    logic [16:0] hold_val = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard on the base instance.
    always @(negedge clk) begin
        if (err === 1'b1)      err_cnt++;
        if (tx_valid === 1'b1) tx_cyc++;
        if (mem_req === 1'b1)  req_cyc++;
        if (busy === 1'b1)     busy_cyc++;
        if (mem_req === 1'b1 && !req_q) begin
            req_rises++;
            hold_val = {mem_we, mem_addr, mem_wdata};
            if (exp_q.size() == 0) chk("unexpected_req", exp_q.size(), 1);
            else begin
                txn_t t;
                t = exp_q.pop_front();
                chk("req_we", mem_we, t.we);
                chk("req_addr", mem_addr, t.addr);
                if (t.we) chk("req_wdata", mem_wdata, t.wdata);
            end
        end else if (mem_req === 1'b1) begin
            chk("req_hold", {mem_we, mem_addr, mem_wdata}, hold_val);
        end
        if (tx_valid === 1'b1 && !txv_q) begin
            if (tx_q.size() == 0) chk("unexpected_tx", tx_q.size(), 1);
            else chk("tx_data", tx_data, tx_q.pop_front());
        end
        req_q = (mem_req === 1'b1);
        txv_q = (tx_valid === 1'b1);
    end

    task automatic send_frame(input logic [9:0] f);
        @(negedge clk);
        rx_data  = f;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic serve(input int k, input logic [7:0] rd);
        repeat (k - 1) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_tx_valid"}, tx_valid, 0);
        chk({name, "_tx_data"}, tx_data, 0);
        chk({name, "_mem_req"}, mem_req, 0);
        chk({name, "_mem_we"}, mem_we, 0);
        chk({name, "_mem_addr"}, mem_addr, 0);
        chk({name, "_mem_wdata"}, mem_wdata, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        int e0, b0, r0, t0, q0;

        vt[0] = '{10'h005, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[1] = '{10'h1A5, 2, 8'h00, 1'b1, 1'b1, 8'h05, 8'hA5};
        vt[2] = '{10'h205, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[3] = '{10'h300, 3, 8'hA5, 1'b1, 1'b0, 8'h05, 8'h00};
        vt[4] = '{10'h300, 1, 8'h3C, 1'b1, 1'b0, 8'h05, 8'h00};
        vt[5] = '{10'h0FF, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[6] = '{10'h15A, 1, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h5A};
        vt[7] = '{10'h1C3, 4, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hC3};
        vt[8] = '{10'h280, 0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        vt[9] = '{10'h3FF, 2, 8'h77, 1'b1, 1'b0, 8'h80, 8'h00};

        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Table-driven single-frame vectors
        for (int i = 0; i < 10; i++) begin
            #1;
            e0 = err_cnt; b0 = busy_cyc; r0 = req_cyc; t0 = tx_cyc;
            if (vt[i].req) begin
                exp_q.push_back('{vt[i].we, vt[i].addr, vt[i].wdata});
                if (!vt[i].we) tx_q.push_back(vt[i].rdata);
            end
            send_frame(vt[i].frame);
            if (vt[i].req) serve(vt[i].k, vt[i].rdata);
            wait_idle("vec_idle");
            @(negedge clk); #1;
            chk("vec_err", err_cnt - e0, 0);
            if (vt[i].req) begin
                chk("vec_req_cycles", req_cyc - r0, vt[i].k);
                chk("vec_busy_cycles", busy_cyc - b0, vt[i].we ? vt[i].k : vt[i].k + TX_HOLD);
                chk("vec_tx_cycles", tx_cyc - t0, vt[i].we ? 0 : TX_HOLD);
                if (!vt[i].we) chk("vec_tx_held", tx_data, vt[i].rdata);
            end
        end

        // Timeout: no ack at all
        send_frame(10'h240);
        #1; e0 = err_cnt; r0 = req_cyc; t0 = tx_cyc;
        exp_q.push_back('{1'b0, 8'h40, 8'h00});
        send_frame(10'h300);
        repeat (25) @(negedge clk);
        #1;
        chk("tmo_req_cycles", req_cyc - r0, TIMEOUT);
        chk("tmo_err_pulses", err_cnt - e0, 1);
        chk("tmo_tx_cycles", tx_cyc - t0, 0);
        chk("tmo_busy", busy, 0);

        // Ack on the TIMEOUT-th edge wins; rd_ptr still 0x40
        e0 = err_cnt; r0 = req_cyc; t0 = tx_cyc;
        exp_q.push_back('{1'b0, 8'h40, 8'h00});
        tx_q.push_back(8'h99);
        send_frame(10'h300);
        serve(TIMEOUT, 8'h99);
        wait_idle("ack_last_idle");
        @(negedge clk); #1;
        chk("ack_last_err", err_cnt - e0, 0);
        chk("ack_last_req_cycles", req_cyc - r0, TIMEOUT);
        chk("ack_last_tx_cycles", tx_cyc - t0, TX_HOLD);
        chk("ack_last_tx_data", tx_data, 8'h99);

        // Frame arriving while a write is pending is dropped
        e0 = err_cnt; q0 = req_rises;
        exp_q.push_back('{1'b1, 8'hFF, 8'h11});
        send_frame(10'h111);
        send_frame(10'h0AA);
        serve(1, 8'h00);
        wait_idle("drop_idle");
        @(negedge clk); #1;
        chk("drop_err_pulses", err_cnt - e0, 1);
        chk("drop_req_count", req_rises - q0, 1);
        exp_q.push_back('{1'b1, 8'hFF, 8'h22});   // wr_ptr unchanged by dropped frame
        send_frame(10'h122);
        serve(1, 8'h00);
        wait_idle("drop_after_idle");

        // rx_valid held high 20 cycles executes one command
        @(negedge clk); #1;
        e0 = err_cnt; q0 = req_rises;
        exp_q.push_back('{1'b1, 8'hFF, 8'hEE});
        rx_data = 10'h1EE; rx_valid = 1'b1;
        @(negedge clk);
        serve(2, 8'h00);
        repeat (17) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk); #1;
        chk("level_req_count", req_rises - q0, 1);
        chk("level_err", err_cnt - e0, 0);
        chk("level_busy", busy, 0);

        // AUTO_INC instance: writes land at 0xFF then wrap to 0x00
        send_frame(10'h0FF);
        exp_q.push_back('{1'b1, 8'hFF, 8'h11});
        send_frame(10'h111);
        chk("inc_req0", i_mem_req, 1);
        chk("inc_addr0", i_mem_addr, 8'hFF);
        chk("inc_wdata0", i_mem_wdata, 8'h11);
        serve(1, 8'h00);
        wait_idle("inc_idle0");
        exp_q.push_back('{1'b1, 8'hFF, 8'h22});
        send_frame(10'h122);
        chk("inc_addr1", i_mem_addr, 8'h00);
        chk("inc_wdata1", i_mem_wdata, 8'h22);
        serve(1, 8'h00);
        wait_idle("inc_idle1");

        // Reset while tx_valid is high
        send_frame(10'h233);
        exp_q.push_back('{1'b0, 8'h33, 8'h00});
        tx_q.push_back(8'h5E);
        send_frame(10'h300);
        serve(1, 8'h5E);
        repeat (3) @(negedge clk);
        chk("pre_rst_tx_valid", tx_valid, 1);
        #1; e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_rst");
        rst = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_err", err_cnt - e0, 0);
        exp_q.push_back('{1'b0, 8'h00, 8'h00});   // rd_ptr cleared by reset
        tx_q.push_back(8'h42);
        send_frame(10'h300);
        serve(1, 8'h42);
        wait_idle("post_rst_idle");
        @(negedge clk); #1;

        chk("exp_q_drained", exp_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
